axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_arb_pkg.sv | 26 ++
 rtl/axi_rd_arbiter_rr_arb2.sv | 12 +
 rtl/axi_rd_arbiter.sv | 144 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared arbiter definitions: state encodings and AR control payload.
// Reusable by read and write arbiters alike.
package axi_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    DATA = ST_DATA
  } arb_state_e;

  // AR sideband fields, everything except address and valid
  typedef struct packed {
    logic       id;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
  } ar_ctrl_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to ~lst.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lst,
  output logic       gnt
);

  always_comb begin
    gnt = (&req) ? ~lst : req[1];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter; one burst outstanding, round-robin grant.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 30,
  parameter int unsigned AXI_DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s0_axi_araddr,
  input  logic [3:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arlock,
  input  logic [3:0]            s0_axi_arcache,
  input  logic [2:0]            s0_axi_arprot,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic                  s0_axi_rid,
  output logic [AXI_DATA_W-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  input  logic                  s1_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s1_axi_araddr,
  input  logic [3:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arlock,
  input  logic [3:0]            s1_axi_arcache,
  input  logic [2:0]            s1_axi_arprot,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic                  s1_axi_rid,
  output logic [AXI_DATA_W-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  output logic                  m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [3:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rid,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  arb_state_e state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       lst_q, lst_d;
  logic       rr_gnt;
  logic       sel_s1;
  ar_ctrl_t   s0_ctrl, s1_ctrl, m_ctrl;

  rr_arb2 u_rr_arb2 (
    .req ({s1_axi_arvalid, s0_axi_arvalid}),
    .lst (lst_q),
    .gnt (rr_gnt)
  );

  assign s0_ctrl = {s0_axi_arid, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst,
                    s0_axi_arlock, s0_axi_arcache, s0_axi_arprot};
  assign s1_ctrl = {s1_axi_arid, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst,
                    s1_axi_arlock, s1_axi_arcache, s1_axi_arprot};
  assign {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arlock, m_axi_arcache, m_axi_arprot} = m_ctrl;

  // R payload is broadcast; only rvalid is steered to the granted requester
  assign s0_axi_rid   = m_axi_rid;
  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rid   = m_axi_rid;
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;
  assign s1_axi_rlast = m_axi_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      lst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lst_q   <= lst_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    lst_d          = lst_q;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;

    // payload follows the grant only in ADDR, otherwise parked on s0
    sel_s1       = (state_q == ADDR) && gnt_q;
    m_ctrl       = sel_s1 ? s1_ctrl : s0_ctrl;
    m_axi_araddr = sel_s1 ? s1_axi_araddr : s0_axi_araddr;

    case (state_q)
      IDLE: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          gnt_d   = rr_gnt;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_axi_arvalid = gnt_q ? s1_axi_arvalid : s0_axi_arvalid;
        if (gnt_q) s1_axi_arready = m_axi_arready;
        else       s0_axi_arready = m_axi_arready;
        if (m_axi_arvalid && m_axi_arready) state_d = DATA;
      end
      DATA: begin
        m_axi_rready = gnt_q ? s1_axi_rready : s0_axi_rready;
        if (gnt_q) s1_axi_rvalid = m_axi_rvalid;
        else       s0_axi_rvalid = m_axi_rvalid;
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
          state_d = IDLE;
          lst_d   = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: random requesters and memory model,
// plus directed grant-order, stall, rready-toggle and mid-burst reset scenarios.
module tb_axi_rd_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  typedef struct packed {
    logic          id;
    logic [1:0]    resp;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic          id;
    logic [AW-1:0] addr;
    logic [3:0]    len;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          s_arid    [2];
  logic [AW-1:0] s_araddr  [2];
  logic [3:0]    s_arlen   [2];
  logic [2:0]    s_arsize  [2];
  logic [1:0]    s_arburst [2];
  logic          s_arlock  [2];
  logic [3:0]    s_arcache [2];
  logic [2:0]    s_arprot  [2];
  logic          s_arvalid [2];
  logic          s_arready [2];
  logic          s_rid     [2];
  logic [DW-1:0] s_rdata   [2];
  logic [1:0]    s_rresp   [2];
  logic          s_rlast   [2];
  logic          s_rvalid  [2];
  logic          s_rready  [2];

  logic          m_arid, m_arlock, m_arvalid, m_arready, m_rready;
  logic [AW-1:0] m_araddr;
  logic [3:0]    m_arlen, m_arcache;
  logic [2:0]    m_arsize, m_arprot;
  logic [1:0]    m_arburst, m_rresp;
  logic          m_rid, m_rlast, m_rvalid;
  logic [DW-1:0] m_rdata;

  int errors = 0;
  int checks = 0;
  beat_t  exp_q0[$];
  beat_t  exp_q1[$];
  burst_t slv_q[$];
  int     grant_log[$];
  bit     ar_stall = 1'b0;
  bit     rr_toggle [2];

  axi_rd_arbiter #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_axi_arid(s_arid[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arlen(s_arlen[0]),
    .s0_axi_arsize(s_arsize[0]), .s0_axi_arburst(s_arburst[0]), .s0_axi_arlock(s_arlock[0]),
    .s0_axi_arcache(s_arcache[0]), .s0_axi_arprot(s_arprot[0]), .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s_arready[0]), .s0_axi_rid(s_rid[0]), .s0_axi_rdata(s_rdata[0]),
    .s0_axi_rresp(s_rresp[0]), .s0_axi_rlast(s_rlast[0]), .s0_axi_rvalid(s_rvalid[0]),
    .s0_axi_rready(s_rready[0]),
    .s1_axi_arid(s_arid[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arlen(s_arlen[1]),
    .s1_axi_arsize(s_arsize[1]), .s1_axi_arburst(s_arburst[1]), .s1_axi_arlock(s_arlock[1]),
    .s1_axi_arcache(s_arcache[1]), .s1_axi_arprot(s_arprot[1]), .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s_arready[1]), .s1_axi_rid(s_rid[1]), .s1_axi_rdata(s_rdata[1]),
    .s1_axi_rresp(s_rresp[1]), .s1_axi_rlast(s_rlast[1]), .s1_axi_rvalid(s_rvalid[1]),
    .s1_axi_rready(s_rready[1]),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
    .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
    .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid),
    .m_axi_rready(m_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory content as seen by the bench: a pure function of address and beat
  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a, input int i);
    return ((DW'(a) << 4) + DW'(i)) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [AW-1:0] a, input int i);
    return 2'((a >> 2) + AW'(i));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One AR transaction from requester k; expected beats queued at handshake
  task automatic issue(input int k, input logic [AW-1:0] addr, input int len, input logic id);
    int n = 0;
    bit done = 1'b0;
    beat_t b;
    @(posedge clk); #1;
    s_arid[k]    = id;
    s_araddr[k]  = addr;
    s_arlen[k]   = 4'(len);
    s_arsize[k]  = 3'($urandom_range(0, 7));
    s_arburst[k] = 2'($urandom_range(0, 3));
    s_arlock[k]  = 1'($urandom_range(0, 1));
    s_arcache[k] = 4'($urandom_range(0, 15));
    s_arprot[k]  = 3'($urandom_range(0, 7));
    s_arvalid[k] = 1'b1;
    while (!done && n < 300) begin
      @(negedge clk);
      if (s_arready[k]) begin
        done = 1'b1;
        grant_log.push_back(k);
        for (int i = 0; i <= len; i++) begin
          b = '{id: id, resp: mem_resp(addr, i), last: (i == len), data: mem_data(addr, i)};
          if (k == 0) exp_q0.push_back(b);
          else        exp_q1.push_back(b);
        end
      end
      n++;
      @(posedge clk); #1;
    end
    s_arvalid[k] = 1'b0;
    if (!done) chk("ar_handshake_timeout", 64'(k), 64'(k + 10));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m_arvalid"}, 64'(m_arvalid), 64'd0);
    chk({tag, "_m_rready"},  64'(m_rready),  64'd0);
    chk({tag, "_s0_arready"}, 64'(s_arready[0]), 64'd0);
    chk({tag, "_s1_arready"}, 64'(s_arready[1]), 64'd0);
    chk({tag, "_s0_rvalid"}, 64'(s_rvalid[0]), 64'd0);
    chk({tag, "_s1_rvalid"}, 64'(s_rvalid[1]), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("in_reset");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || slv_q.size() != 0) && n < 800) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 800), 64'd1);
  endtask

  // Memory-side model: accepts AR, returns beats with random valid gaps
  initial begin
    bit ar_fire, r_fire, rst_s;
    burst_t cap;
    int beat = 0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = 1'b0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    forever begin
      @(negedge clk);
      ar_fire = m_arvalid && m_arready;
      r_fire  = m_rvalid && m_rready;
      rst_s   = rst;
      cap     = '{id: m_arid, addr: m_araddr, len: m_arlen};
      @(posedge clk); #1;
      if (rst_s || rst) begin
        slv_q.delete();
        beat = 0;
        m_rvalid = 1'b0;
      end else begin
        if (r_fire && slv_q.size() != 0) begin
          m_rvalid = 1'b0;
          if (beat == int'(slv_q[0].len)) begin
            void'(slv_q.pop_front());
            beat = 0;
          end else beat++;
        end
        if (ar_fire) slv_q.push_back(cap);
        if (!m_rvalid && slv_q.size() != 0 && $urandom_range(0, 3) != 0) begin
          m_rvalid = 1'b1;
          m_rid    = slv_q[0].id;
          m_rdata  = mem_data(slv_q[0].addr, beat);
          m_rresp  = mem_resp(slv_q[0].addr, beat);
          m_rlast  = (beat == int'(slv_q[0].len));
        end
      end
      m_arready = !ar_stall && ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        s_rready[k] = rr_toggle[k] ? ~s_rready[k] : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks AR forwarding
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (s_rvalid[k]) begin
          chk("r_expected", 64'((k == 0) ? exp_q0.size() != 0 : exp_q1.size() != 0), 64'd1);
          if (s_rready[k] && ((k == 0) ? exp_q0.size() != 0 : exp_q1.size() != 0)) begin
            b = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk((k == 0) ? "s0_beat" : "s1_beat",
                64'({s_rid[k], s_rresp[k], s_rlast[k], s_rdata[k]}), 64'(b));
          end
        end
        if (s_arready[k]) begin
          chk("ar_fwd",
              64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}),
              64'({s_arid[k], s_araddr[k], s_arlen[k], s_arsize[k], s_arburst[k],
                   s_arlock[k], s_arcache[k], s_arprot[k]}));
          chk("ar_valid_fwd", 64'(m_arvalid), 64'(s_arvalid[k]));
        end
      end
      if (s_arready[0] || s_arready[1])
        chk("single_arready", 64'(s_arready[0] && s_arready[1]), 64'd0);
      if (s_rvalid[0] || s_rvalid[1])
        chk("single_rvalid", 64'(s_rvalid[0] && s_rvalid[1]), 64'd0);
    end
  end

  initial begin
    int n, beats, seen1;
    for (int k = 0; k < 2; k++) begin
      s_arid[k] = 1'b0; s_araddr[k] = '0; s_arlen[k] = '0; s_arsize[k] = '0;
      s_arburst[k] = '0; s_arlock[k] = 1'b0; s_arcache[k] = '0; s_arprot[k] = '0;
      s_arvalid[k] = 1'b0; s_rready[k] = 1'b0; rr_toggle[k] = 1'b0;
    end
    do_reset();

    // lone s0 request: one idle cycle, then address 0x100, four beats, s1 silent
    fork
      issue(0, AW'(32'h100), 3, 1'b1);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("lat_idle_arvalid", 64'(m_arvalid), 64'd0);
        chk("lat_idle_arready", 64'(s_arready[0]), 64'd0);
        @(negedge clk);
        chk("lat_addr_arvalid", 64'(m_arvalid), 64'd1);
        chk("lat_addr_araddr", 64'(m_araddr), 64'h100);
        beats = 0; seen1 = 0; n = 0;
        while (beats < 4 && n < 200) begin
          @(negedge clk);
          if (s_rvalid[0] && s_rready[0]) beats++;
          if (s_rvalid[1]) seen1++;
          n++;
        end
        chk("solo_beats", 64'(beats), 64'd4);
        chk("solo_s1_rvalid", 64'(seen1), 64'd0);
      end
    join
    wait_drain();

    // simultaneous requests after reset: s0 first, s1 granted right after rlast
    do_reset();
    grant_log.delete();
    fork
      issue(0, AW'(32'h400), 3, 1'b0);
      issue(1, AW'(32'h800), 2, 1'b1);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(s_rvalid[0] && s_rready[0] && s_rlast[0]) && n < 300);
        @(negedge clk);
        chk("handover_idle", 64'(m_arvalid), 64'd0);
        @(negedge clk);
        chk("handover_arvalid", 64'(m_arvalid), 64'd1);
        chk("handover_araddr", 64'(m_araddr), 64'h800);
        chk("handover_arready", 64'(s_arready[1]), 64'(m_arready));
      end
    join
    wait_drain();
    chk("tie_first_s0", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'd0);

    // both requesting back to back: alternating grants
    do_reset();
    grant_log.delete();
    fork
      begin issue(0, AW'(32'h1000), 3, 1'b0); issue(0, AW'(32'h1100), 3, 1'b0); end
      begin issue(1, AW'(32'h2000), 3, 1'b1); issue(1, AW'(32'h2100), 3, 1'b1); end
    join
    wait_drain();
    chk("rr_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", 64'(grant_log[i]), 64'(i % 2));

    // master arready held low: state parked in ADDR, both arready low
    do_reset();
    ar_stall = 1'b1;
    fork
      issue(0, AW'(32'h3000), 3, 1'b0);
      issue(1, AW'(32'h3300), 3, 1'b1);
      begin
        @(posedge clk);
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_addr", 64'(m_arvalid), 64'd1);
          chk("stall_araddr", 64'(m_araddr), 64'h3000);
          chk("stall_s0_arready", 64'(s_arready[0]), 64'd0);
          chk("stall_s1_arready", 64'(s_arready[1]), 64'd0);
        end
        ar_stall = 1'b0;
      end
    join
    wait_drain();

    // s1 rready toggling: m_rready mirrors it through the whole burst
    rr_toggle[1] = 1'b1;
    issue(1, AW'(32'h4440), 3, 1'b1);
    beats = 0; n = 0;
    do begin
      @(negedge clk);
      chk("rready_mirror", 64'(m_rready), 64'(s_rready[1]));
      if (s_rvalid[1] && s_rready[1]) beats++;
      n++;
    end while (!(s_rvalid[1] && s_rready[1] && s_rlast[1]) && n < 200);
    chk("toggle_beats", 64'(beats), 64'd4);
    rr_toggle[1] = 1'b0;
    wait_drain();

    // reset after beat 2 of 4; the next tie must still go to s0
    do_reset();
    issue(0, AW'(32'h5000), 3, 1'b0);
    wait_drain();
    issue(0, AW'(32'h5200), 3, 1'b1);
    beats = 0; n = 0;
    while (beats < 2 && n < 200) begin
      @(negedge clk);
      if (s_rvalid[0] && s_rready[0]) beats++;
      n++;
    end
    chk("mid_reset_beats", 64'(beats), 64'd2);
    do_reset();
    grant_log.delete();
    fork
      issue(0, AW'(32'h6000), 1, 1'b0);
      issue(1, AW'(32'h6600), 1, 1'b1);
    join
    wait_drain();
    chk("post_reset_tie_s0", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'd0);

    // randomized traffic from both requesters
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(0, AW'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(1, AW'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      end
    join
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
